// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: sequencing controller for the keypad combination lock.
// The controller collects one BCD digit per key press into an entry buffer.
// On enter, it compares the buffer with the stored code. It holds the lock
// open for a fixed time, and it locks out the keypad after repeated failures.
// The code can be reprogrammed while the lock is open.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bcd          - keypad digit, valid while one_press=1
//   one_press    - exactly one key held (debounced upstream)
//   enter        - submit (rising edge)
//   clear        - discard entry buffer (rising edge)
//   set_mode     - request code programming (rising edge)
//   unlocked     - lock open
//   lockout      - input locked out after too many failures
//   error        - one-cycle pulse on a rejected submission
//   set_active   - code-programming state
//   digit_count  - digits held in the entry buffer
module combo_lock_ctrl #(
    parameter int unsigned CODE_LEN       = 4,
    parameter logic [27:0] DEFAULT_CODE   = 28'h0001234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 50_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] bcd,
    input  logic       one_press,
    input  logic       enter,
    input  logic       clear,
    input  logic       set_mode,
    output logic       unlocked,
    output logic       lockout,
    output logic       error,
    output logic       set_active,
    output logic [2:0] digit_count
);

    localparam int unsigned BUF_W   = CODE_LEN * 4;
    localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned FAIL_W  = 4;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_SET     = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    code_q, code_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                prev_press_q, prev_enter_q, prev_clear_q, prev_set_q;
    logic                unlocked_q, lockout_q, error_q, set_active_q;
    logic                error_d;

    logic                ev_clr, ev_ent, ev_set, ev_dig;
    logic                take_clr, take_ent, take_set, take_dig;
    logic                buf_full, code_match, tmr_zero;
    logic [BUF_W-1:0]    buf_shift;
    logic [FAIL_W-1:0]   fail_inc;

    // Rising-edge events, resolved by priority: clear > enter > set_mode > digit
    always_comb begin
        ev_clr   = clear & ~prev_clear_q;
        ev_ent   = enter & ~prev_enter_q;
        ev_set   = set_mode & ~prev_set_q;
        ev_dig   = one_press & ~prev_press_q;
        take_clr = ev_clr;
        take_ent = ev_ent & ~ev_clr;
        take_set = ev_set & ~ev_clr & ~ev_ent;
        take_dig = ev_dig & ~ev_clr & ~ev_ent & ~ev_set;
    end

    // Newest digit enters at the bottom, so the first digit ends up most significant
    assign buf_shift  = BUF_W'({buf_q, bcd});
    assign buf_full   = (cnt_q == CNT_W'(CODE_LEN));
    assign code_match = buf_full && (buf_q == code_q);
    assign tmr_zero   = (tmr_q == '0);
    assign fail_inc   = FAIL_W'(fail_q + FAIL_W'(1));

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        tmr_d   = tmr_q;
        error_d = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                if (take_clr) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (take_ent) begin
                    buf_d = '0;
                    cnt_d = '0;
                    if (code_match) begin
                        state_d = ST_OPEN;
                        fail_d  = '0;
                        tmr_d   = TMR_W'(UNLOCK_CYCLES - 1);
                    end else begin
                        error_d = 1'b1;
                        fail_d  = fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
                            state_d = ST_LOCKOUT;
                            tmr_d   = TMR_W'(LOCKOUT_CYCLES - 1);
                        end
                    end
                end else if (take_dig && !buf_full) begin
                    buf_d = buf_shift;
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end

            // Expiry wins over same-cycle events so the open time is exact
            ST_OPEN: begin
                if (tmr_zero) begin
                    state_d = ST_LOCKED;
                end else begin
                    tmr_d = TMR_W'(tmr_q - TMR_W'(1));
                    if (take_ent) begin
                        state_d = ST_LOCKED;
                    end else if (take_set) begin
                        state_d = ST_SET;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end

            ST_SET: begin
                if (take_clr) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if (take_ent) begin
                    if (buf_full) begin
                        code_d = buf_q;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = ST_LOCKED;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (take_set) begin
                    state_d = ST_LOCKED;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else if (take_dig && !buf_full) begin
                    buf_d = buf_shift;
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end

            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                end else begin
                    tmr_d = TMR_W'(tmr_q - TMR_W'(1));
                end
            end

            default: state_d = ST_LOCKED;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOCKED;
            code_q       <= DEFAULT_CODE[BUF_W-1:0];
            buf_q        <= '0;
            cnt_q        <= '0;
            fail_q       <= '0;
            tmr_q        <= '0;
            prev_press_q <= 1'b0;
            prev_enter_q <= 1'b0;
            prev_clear_q <= 1'b0;
            prev_set_q   <= 1'b0;
            unlocked_q   <= 1'b0;
            lockout_q    <= 1'b0;
            error_q      <= 1'b0;
            set_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            fail_q       <= fail_d;
            tmr_q        <= tmr_d;
            prev_press_q <= one_press;
            prev_enter_q <= enter;
            prev_clear_q <= clear;
            prev_set_q   <= set_mode;
            unlocked_q   <= (state_d == ST_OPEN);
            lockout_q    <= (state_d == ST_LOCKOUT);
            error_q      <= error_d;
            set_active_q <= (state_d == ST_SET);
        end
    end

    assign unlocked    = unlocked_q;
    assign lockout     = lockout_q;
    assign error       = error_q;
    assign set_active  = set_active_q;
    assign digit_count = cnt_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Bench for combo_lock_ctrl: directed scenarios plus randomized key traffic,
// checked every cycle against a behavioural model of the lock rules.
module tb_combo_lock_ctrl;

    localparam int unsigned CODE_LEN  = 4;
    localparam int unsigned MAX_FAILS = 3;
    localparam int unsigned UNLOCK    = 8;
    localparam int unsigned LOCKOUT   = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] bcd;
    logic       one_press, enter, clear, set_mode;
    logic       unlocked, lockout, error, set_active;
    logic [2:0] digit_count;

    int checks   = 0;
    int failures = 0;

    combo_lock_ctrl #(
        .CODE_LEN      (CODE_LEN),
        .DEFAULT_CODE  (28'h0001234),
        .MAX_FAILS     (MAX_FAILS),
        .UNLOCK_CYCLES (UNLOCK),
        .LOCKOUT_CYCLES(LOCKOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd        (bcd),
        .one_press  (one_press),
        .enter      (enter),
        .clear      (clear),
        .set_mode   (set_mode),
        .unlocked   (unlocked),
        .lockout    (lockout),
        .error      (error),
        .set_active (set_active),
        .digit_count(digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_q[$];
    int m_code[CODE_LEN];
    int m_open_left = 0;
    int m_lock_left = 0;
    int m_fails     = 0;
    bit m_set       = 0;
    bit m_err       = 0;
    bit p_press = 0, p_enter = 0, p_clear = 0, p_setm = 0;

    task automatic model_reset();
        m_q.delete();
        m_code[0] = 1; m_code[1] = 2; m_code[2] = 3; m_code[3] = 4;
        m_open_left = 0;
        m_lock_left = 0;
        m_fails = 0;
        m_set = 0;
        m_err = 0;
        p_press = 0; p_enter = 0; p_clear = 0; p_setm = 0;
    endtask

    function automatic bit q_matches_code();
        if (m_q.size() != CODE_LEN) return 0;
        for (int i = 0; i < CODE_LEN; i++)
            if (m_q[i] != m_code[i]) return 0;
        return 1;
    endfunction

    task automatic model_step();
        bit ec, ee, es, ed, tc, te, ts, td;
        ec = clear && !p_clear;
        ee = enter && !p_enter;
        es = set_mode && !p_setm;
        ed = one_press && !p_press;
        tc = ec;
        te = ee && !ec;
        ts = es && !ec && !ee;
        td = ed && !ec && !ee && !es;
        p_clear = clear; p_enter = enter; p_setm = set_mode; p_press = one_press;
        m_err = 0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_fails = 0;
                m_q.delete();
            end
        end else if (m_open_left > 0) begin
            m_open_left--;
            if (m_open_left > 0) begin
                if (te) m_open_left = 0;
                else if (ts) begin
                    m_open_left = 0;
                    m_set = 1;
                    m_q.delete();
                end
            end
        end else if (m_set) begin
            if (tc) m_q.delete();
            else if (te) begin
                if (m_q.size() == CODE_LEN)
                    for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_q[i];
                else
                    m_err = 1;
                m_set = 0;
                m_q.delete();
            end else if (ts) begin
                m_set = 0;
                m_q.delete();
            end else if (td && m_q.size() < CODE_LEN) m_q.push_back(int'(bcd));
        end else begin
            if (tc) m_q.delete();
            else if (te) begin
                if (q_matches_code()) begin
                    m_open_left = UNLOCK;
                    m_fails = 0;
                end else begin
                    m_err = 1;
                    m_fails++;
                    if (m_fails == MAX_FAILS) m_lock_left = LOCKOUT;
                end
                m_q.delete();
            end else if (td && m_q.size() < CODE_LEN) m_q.push_back(int'(bcd));
        end
    endtask

    // Model update at each edge, compare shortly after
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        chk("unlocked", 32'(unlocked), 32'(m_open_left > 0));
        chk("lockout", 32'(lockout), 32'(m_lock_left > 0));
        chk("error", 32'(error), 32'(m_err));
        chk("set_active", 32'(set_active), 32'(m_set));
        chk("digit_count", 32'(digit_count), 32'(m_q.size()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int d, input int hold);
        @(negedge clk);
        bcd = 4'(d);
        one_press = 1'b1;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk);
        one_press = 1'b0;
    endtask

    task automatic press_enter();
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic press_set();
        @(negedge clk);
        set_mode = 1'b1;
        @(negedge clk);
        set_mode = 1'b0;
    endtask

    task automatic type4(input int a, input int b, input int c, input int d);
        press(a, 1); press(b, 1); press(c, 1); press(d, 1);
    endtask

    task automatic async_reset(input string nm);
        #2;
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_unlocked"}, 32'(unlocked), 0);
        chk({nm, "_rst_lockout"}, 32'(lockout), 0);
        chk({nm, "_rst_error"}, 32'(error), 0);
        chk({nm, "_rst_set_active"}, 32'(set_active), 0);
        chk({nm, "_rst_count"}, 32'(digit_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bcd = '0; one_press = 0; enter = 0; clear = 0; set_mode = 0;
        #1;
        chk("reset_unlocked", 32'(unlocked), 0);
        chk("reset_count", 32'(digit_count), 0);
        drain(2);
        rst_n = 1'b1;

        // 1: correct code, count steps, exact open time
        press(1, 1); chk("cnt1", 32'(digit_count), 1);
        press(2, 1); chk("cnt2", 32'(digit_count), 2);
        press(3, 1); chk("cnt3", 32'(digit_count), 3);
        press(4, 1); chk("cnt4", 32'(digit_count), 4);
        press_enter();
        chk("open_after_enter", 32'(unlocked), 1);
        chk("open_count_cleared", 32'(digit_count), 0);
        n = 0;
        while (unlocked && n < 100) begin n++; @(negedge clk); end
        chk("unlock_len", 32'(n), UNLOCK);

        // 2: three failures -> lockout
        for (int k = 0; k < 3; k++) begin
            type4(1, 2, 3, 5);
            press_enter();
            chk("fail_error", 32'(error), 1);
        end
        chk("lockout_on", 32'(lockout), 1);
        n = 0;
        while (lockout && n < 100) begin
            n++;
            bcd = 4'd5;
            one_press = n[0];
            @(negedge clk);
        end
        one_press = 1'b0;
        chk("lockout_len", 32'(n), LOCKOUT);
        @(negedge clk);
        chk("lockout_count0", 32'(digit_count), 0);
        type4(1, 2, 3, 4);
        press_enter();
        chk("unlock_after_lockout", 32'(unlocked), 1);
        drain(12);

        // 3: held key is one event, count saturates
        press(7, 10);
        press(8, 1);
        chk("held_key_count", 32'(digit_count), 2);
        press(9, 1); press(9, 1); press(9, 1);
        chk("saturate_count", 32'(digit_count), 4);
        press_enter();
        chk("saturate_error", 32'(error), 1);

        // 4: reprogram the code
        type4(1, 2, 3, 4);
        press_enter();
        press_set();
        chk("set_active_on", 32'(set_active), 1);
        type4(9, 8, 7, 6);
        press_enter();
        chk("set_active_off", 32'(set_active), 0);
        chk("set_no_error", 32'(error), 0);
        type4(1, 2, 3, 4);
        press_enter();
        chk("old_code_rejected", 32'(error), 1);
        type4(9, 8, 7, 6);
        press_enter();
        chk("new_code_opens", 32'(unlocked), 1);
        drain(12);

        // 5: clear and enter together
        press(1, 1); press(2, 1);
        @(negedge clk);
        clear = 1'b1; enter = 1'b1;
        @(negedge clk);
        clear = 1'b0; enter = 1'b0;
        chk("clr_ent_count", 32'(digit_count), 0);
        chk("clr_ent_error", 32'(error), 0);
        chk("clr_ent_locked", 32'(unlocked), 0);

        // 6: reset mid-OPEN and mid-SET restores the default code
        type4(9, 8, 7, 6);
        press_enter();
        chk("pre_reset_open", 32'(unlocked), 1);
        drain(2);
        async_reset("open");
        type4(9, 8, 7, 6);
        press_enter();
        chk("prog_code_lost", 32'(error), 1);
        type4(1, 2, 3, 4);
        press_enter();
        chk("default_restored", 32'(unlocked), 1);
        press_set();
        press(5, 1); press(5, 1);
        chk("pre_reset_set", 32'(set_active), 1);
        async_reset("set");
        type4(1, 2, 3, 4);
        press_enter();
        chk("default_after_set_rst", 32'(unlocked), 1);
        drain(12);

        // 7: randomized traffic
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: press($urandom_range(0, 9), $urandom_range(1, 3));
                4: type4(m_code[0], m_code[1], m_code[2], m_code[3]);
                5: press_enter();
                6: begin @(negedge clk); clear = 1'b1; @(negedge clk); clear = 1'b0; end
                7: press_set();
                8: begin
                    @(negedge clk);
                    bcd = 4'($urandom_range(0, 15));
                    one_press = 1'($urandom_range(0, 1));
                    enter = 1'($urandom_range(0, 1));
                    clear = 1'($urandom_range(0, 1));
                    set_mode = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    one_press = 0; enter = 0; clear = 0; set_mode = 0;
                end
                default: drain($urandom_range(0, 5));
            endcase
        end
        one_press = 0; enter = 0; clear = 0; set_mode = 0;
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Sequencing controller for the keypad combination lock. Consumes the BCD digit and `one_press` strobe from the keypad encoder, accepts one digit per key press, and compares the entered sequence against a stored code on `enter`. Drives the unlock, error and lockout indications, and supports reprogramming the code while unlocked. Sits between the keypad encoder and the lock actuator/display logic.

## Interface
- `CODE_LEN`, 4: digits per code; legal range 1–7.
- `DEFAULT_CODE`, 28'h0001234: code loaded at reset; 4 bits per digit, right-justified, digit 0 (first entered) most significant of the used field.
- `MAX_FAILS`, 3: consecutive failed attempts that trigger lockout; range 1–15.
- `UNLOCK_CYCLES`, 50_000_000: cycles `unlocked` is held.
- `LOCKOUT_CYCLES`, 500_000_000: cycles `lockout` is held.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `bcd` in 4: digit from the keypad encoder; valid only while `one_press`=1.
- `one_press` in 1: exactly one key held; synchronous and debounced upstream.
- `enter` in 1: submit strobe; level, acted on only at its rising edge.
- `clear` in 1: discard the entry buffer; level, acted on only at its rising edge.
- `set_mode` in 1: request code programming; level, acted on only at its rising edge.
- `unlocked` out 1: lock open.
- `lockout` out 1: input locked out after too many failures.
- `error` out 1: one-cycle pulse on a rejected submission.
- `set_active` out 1: controller is in the code-programming state.
- `digit_count` out 3: digits currently held in the entry buffer.

## Operation
- Edge detection: `one_press`, `enter`, `clear` and `set_mode` each have a registered previous value. An event is previous=0 and current=1. Holding a key produces one event. `bcd` is sampled in the cycle of the `one_press` event.
- Entry buffer: CODE_LEN×4-bit shift register plus `digit_count`. A digit event shifts the digit in and increments the count. Once the count equals CODE_LEN, further digits are discarded; buffer and count are unchanged.
- Event priority within one cycle is `clear` > `enter` > `set_mode` > digit. Lower-priority events in the same cycle are dropped.
- States: LOCKED, OPEN, SET, LOCKOUT.
- LOCKED:
  - Accepts digits and `clear`.
  - On `enter`, a match requires count==CODE_LEN and buffer==code. Match: go to OPEN, clear fail_cnt.
  - On mismatch, including a short entry: pulse `error` and increment fail_cnt. If the new fail_cnt equals MAX_FAILS, go to LOCKOUT; otherwise stay in LOCKED.
  - The buffer is cleared on every `enter`.
  - `set_mode` is ignored.
- OPEN:
  - Timer loads UNLOCK_CYCLES on entry; `unlocked`=1.
  - When the timer expires, go to LOCKED.
  - `enter` relocks immediately by going to LOCKED.
  - `set_mode` goes to SET with the buffer cleared.
  - Digits and `clear` are ignored.
- SET:
  - `set_active`=1; accepts digits and `clear`.
  - `enter` with count==CODE_LEN: write the buffer to the code register, go to LOCKED.
  - `enter` with a short count: pulse `error`, keep the old code, go to LOCKED. fail_cnt is not affected.
  - `set_mode` aborts to LOCKED with the code unchanged.
  - The buffer is cleared on exit.
- LOCKOUT:
  - Timer loads LOCKOUT_CYCLES on entry; `lockout`=1.
  - All inputs are ignored.
  - When the timer expires, go to LOCKED with fail_cnt=0 and the buffer cleared.
- Timer: one down-counter shared by OPEN and LOCKOUT, sized to the larger of the two parameters.
- Reset values: state=LOCKED, code=DEFAULT_CODE, buffer=0, fail_cnt=0, timer=0, edge-detect registers=0. All outputs are 0.
- Reset is honoured mid-operation from any state. Any programmed code is lost and replaced by DEFAULT_CODE.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- An event sampled at edge N takes effect at N+1. `digit_count`, `unlocked`, `lockout`, `set_active` and the `error` pulse all change at N+1.
- `unlocked` is high for exactly UNLOCK_CYCLES cycles, then low, unless relocked early by `enter`.
- `lockout` is high for exactly LOCKOUT_CYCLES cycles.
- `error` is high for exactly one cycle per rejected submission.
- Back-to-back key events need one cycle with `one_press`=0 between them. A direct key change with no release is one event.

## Test plan
- Reset, then press 1,2,3,4 and `enter`: `digit_count` steps 1..4; `unlocked`=1 for exactly UNLOCK_CYCLES (bench uses 8), then 0.
- Press 1,2,3,5 and `enter` three times (MAX_FAILS=3): `error` pulses on each submission; after the third, `lockout`=1 for 16 cycles (LOCKOUT_CYCLES=16), and presses during lockout leave `digit_count`=0. Afterwards 1,2,3,4 unlocks.
- Hold key 7 for 10 cycles, then press 8: `digit_count`=2. Press 9,9,9: count saturates at 4. `enter` gives `error`.
- Unlock, `set_mode`, press 9,8,7,6, `enter`: `set_active` 1→0. Then 1,2,3,4 fails and 9,8,7,6 unlocks.
- `clear` and `enter` rising in the same cycle with 2 digits held: buffer cleared, no `error`, state stays LOCKED.
- Assert `rst_n` low mid-OPEN and mid-SET: all outputs are 0 asynchronously; the code reverts to 1234.
